vec_agg_sched: RTL and testbench

VEC_AGG_SCHED -- requirements
Module: vec_agg_sched

---
 rtl/vec_agg_sched.sv | 188 ++++++++++++++++++
 tb/tb_vec_agg_sched.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/vec_agg_sched.sv
// Three-input, four-output packet scheduler. Each output has a registered slot and a round-robin arbiter.
// Define VEC_AGG_SCHED_STATS_EN to add saturating per-output handshake counters (io_stat_count_k).

module vec_agg_lane #(
  parameter int RR_EN_RESET = 1
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             flush,
  input  logic             outReady,
  input  logic [2:0]       req,
  input  logic [2:0][63:0] inPkt,
  output logic [2:0]       grant,
  output logic             outValid,
  output logic [63:0]      outPkt
`ifdef VEC_AGG_SCHED_STATS_EN
  ,
  output logic [15:0]      statCount
`endif
);
  localparam logic [1:0] PTR_RST = (RR_EN_RESET != 0) ? 2'd0 : 2'd2;

  logic [1:0] ptr;
  logic [1:0] gIdx;
  logic [2:0] sum;
  logic [1:0] idx;
  logic       found;
  logic       free;

  assign free = !outValid || outReady;

  // Search ptr, ptr+1, ptr+2 (mod 3); the first requester wins.
  always_comb begin
    grant = '0;
    gIdx  = ptr;
    found = 1'b0;
    sum   = '0;
    idx   = '0;
    if (reset && !flush && free) begin
      for (int off = 0; off < 3; off++) begin
        sum = {1'b0, ptr} + 3'(off);
        idx = (sum >= 3'd3) ? 2'(sum - 3'd3) : sum[1:0];
        if (!found && req[idx]) begin
          found      = 1'b1;
          grant[idx] = 1'b1;
          gIdx       = idx;
        end
      end
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      outValid <= 1'b0;
      outPkt   <= '0;
      ptr      <= PTR_RST;
    end else if (flush) begin
      outValid <= 1'b0;
    end else if (found) begin
      outValid <= 1'b1;
      outPkt   <= inPkt[gIdx];
      ptr      <= (gIdx == 2'd2) ? 2'd0 : gIdx + 2'd1;
    end else if (outReady) begin
      outValid <= 1'b0;
    end
  end

`ifdef VEC_AGG_SCHED_STATS_EN
  // Counts handshakes even in a flush cycle; flush never clears the count.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset)
      statCount <= '0;
    else if (outValid && outReady && statCount != 16'hFFFF)
      statCount <= statCount + 16'd1;
  end
`endif
endmodule

module vec_agg_sched #(
  parameter int DEST_LSB    = 0,
  parameter int RR_EN_RESET = 1
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        io_in_valid_0,
  input  logic        io_in_valid_1,
  input  logic        io_in_valid_2,
  output logic        io_in_ready_0,
  output logic        io_in_ready_1,
  output logic        io_in_ready_2,
  input  logic [15:0] io_inPacket_tx_header_0,
  input  logic [15:0] io_inPacket_tx_header_1,
  input  logic [15:0] io_inPacket_tx_header_2,
  input  logic [15:0] io_inPacket_tx_addr_0,
  input  logic [15:0] io_inPacket_tx_addr_1,
  input  logic [15:0] io_inPacket_tx_addr_2,
  input  logic [31:0] io_inPacket_tx_data_0,
  input  logic [31:0] io_inPacket_tx_data_1,
  input  logic [31:0] io_inPacket_tx_data_2,
  output logic        io_out_valid_0,
  output logic        io_out_valid_1,
  output logic        io_out_valid_2,
  output logic        io_out_valid_3,
  input  logic        io_out_ready_0,
  input  logic        io_out_ready_1,
  input  logic        io_out_ready_2,
  input  logic        io_out_ready_3,
  output logic [15:0] io_outPacket_rx_header_0,
  output logic [15:0] io_outPacket_rx_header_1,
  output logic [15:0] io_outPacket_rx_header_2,
  output logic [15:0] io_outPacket_rx_header_3,
  output logic [15:0] io_outPacket_rx_addr_0,
  output logic [15:0] io_outPacket_rx_addr_1,
  output logic [15:0] io_outPacket_rx_addr_2,
  output logic [15:0] io_outPacket_rx_addr_3,
  output logic [31:0] io_outPacket_rx_data_0,
  output logic [31:0] io_outPacket_rx_data_1,
  output logic [31:0] io_outPacket_rx_data_2,
  output logic [31:0] io_outPacket_rx_data_3,
  input  logic        io_flush
`ifdef VEC_AGG_SCHED_STATS_EN
  ,
  output logic [15:0] io_stat_count_0,
  output logic [15:0] io_stat_count_1,
  output logic [15:0] io_stat_count_2,
  output logic [15:0] io_stat_count_3
`endif
);
  logic [2:0]            inValid;
  logic [2:0][15:0]      inHdr;
  logic [2:0][63:0]      inPkt;
  logic [2:0][1:0]       dest;
  logic [3:0][2:0]       reqMat;
  logic [3:0][2:0]       grantMat;
  logic [2:0]            inReady;
  logic [3:0]            outValid;
  logic [3:0]            outReady;
  logic [3:0][63:0]      outPkt;

  assign inValid  = {io_in_valid_2, io_in_valid_1, io_in_valid_0};
  assign inHdr    = {io_inPacket_tx_header_2, io_inPacket_tx_header_1, io_inPacket_tx_header_0};
  assign inPkt[0] = {io_inPacket_tx_header_0, io_inPacket_tx_addr_0, io_inPacket_tx_data_0};
  assign inPkt[1] = {io_inPacket_tx_header_1, io_inPacket_tx_addr_1, io_inPacket_tx_data_1};
  assign inPkt[2] = {io_inPacket_tx_header_2, io_inPacket_tx_addr_2, io_inPacket_tx_data_2};
  assign outReady = {io_out_ready_3, io_out_ready_2, io_out_ready_1, io_out_ready_0};

  // Each input requests exactly one output, so OR-ing the per-output grants is one-hot per input.
  always_comb begin
    inReady = '0;
    for (int i = 0; i < 3; i++) begin
      dest[i] = inHdr[i][DEST_LSB+1 -: 2];
      for (int k = 0; k < 4; k++) begin
        reqMat[k][i] = inValid[i] && (dest[i] == 2'(k));
        inReady[i]   = inReady[i] | grantMat[k][i];
      end
    end
  end

`ifdef VEC_AGG_SCHED_STATS_EN
  logic [3:0][15:0] statCount;
  assign {io_stat_count_3, io_stat_count_2, io_stat_count_1, io_stat_count_0} = statCount;
`endif

  for (genvar k = 0; k < 4; k++) begin : gLane
    vec_agg_lane #(.RR_EN_RESET(RR_EN_RESET)) uLane (
      .clock    (clock),
      .reset    (reset),
      .flush    (io_flush),
      .outReady (outReady[k]),
      .req      (reqMat[k]),
      .inPkt    (inPkt),
      .grant    (grantMat[k]),
      .outValid (outValid[k]),
      .outPkt   (outPkt[k])
`ifdef VEC_AGG_SCHED_STATS_EN
      ,
      .statCount(statCount[k])
`endif
    );
  end

  assign {io_in_ready_2, io_in_ready_1, io_in_ready_0} = inReady;
  assign {io_out_valid_3, io_out_valid_2, io_out_valid_1, io_out_valid_0} = outValid;
  assign {io_outPacket_rx_header_0, io_outPacket_rx_addr_0, io_outPacket_rx_data_0} = outPkt[0];
  assign {io_outPacket_rx_header_1, io_outPacket_rx_addr_1, io_outPacket_rx_data_1} = outPkt[1];
  assign {io_outPacket_rx_header_2, io_outPacket_rx_addr_2, io_outPacket_rx_data_2} = outPkt[2];
  assign {io_outPacket_rx_header_3, io_outPacket_rx_addr_3, io_outPacket_rx_data_3} = outPkt[3];
endmodule

// File: tb/tb_vec_agg_sched.sv
// Scoreboard bench for vec_agg_sched: stimulus pushes expected packets per output, a negedge monitor pops on handshakes.
module tb_vec_agg_sched;
  logic        clock = 1'b0;
  logic        reset;
  logic        flush;
  logic        inValid [3];
  logic        inReady [3];
  logic [15:0] hdr [3];
  logic [15:0] adr [3];
  logic [31:0] dat [3];
  logic        outValid [4];
  logic        outReady [4];
  logic [15:0] oHdr [4];
  logic [15:0] oAdr [4];
  logic [31:0] oDat [4];
`ifdef VEC_AGG_SCHED_STATS_EN
  logic [15:0] stat [4];
`endif

  logic [63:0] q [4][$];
  int vecs = 0;
  int errs = 0;
  bit sbEn = 1'b1;

  always #5 clock = ~clock;

  vec_agg_sched dut (
    .clock(clock), .reset(reset),
    .io_in_valid_0(inValid[0]), .io_in_valid_1(inValid[1]), .io_in_valid_2(inValid[2]),
    .io_in_ready_0(inReady[0]), .io_in_ready_1(inReady[1]), .io_in_ready_2(inReady[2]),
    .io_inPacket_tx_header_0(hdr[0]), .io_inPacket_tx_header_1(hdr[1]), .io_inPacket_tx_header_2(hdr[2]),
    .io_inPacket_tx_addr_0(adr[0]), .io_inPacket_tx_addr_1(adr[1]), .io_inPacket_tx_addr_2(adr[2]),
    .io_inPacket_tx_data_0(dat[0]), .io_inPacket_tx_data_1(dat[1]), .io_inPacket_tx_data_2(dat[2]),
    .io_out_valid_0(outValid[0]), .io_out_valid_1(outValid[1]),
    .io_out_valid_2(outValid[2]), .io_out_valid_3(outValid[3]),
    .io_out_ready_0(outReady[0]), .io_out_ready_1(outReady[1]),
    .io_out_ready_2(outReady[2]), .io_out_ready_3(outReady[3]),
    .io_outPacket_rx_header_0(oHdr[0]), .io_outPacket_rx_header_1(oHdr[1]),
    .io_outPacket_rx_header_2(oHdr[2]), .io_outPacket_rx_header_3(oHdr[3]),
    .io_outPacket_rx_addr_0(oAdr[0]), .io_outPacket_rx_addr_1(oAdr[1]),
    .io_outPacket_rx_addr_2(oAdr[2]), .io_outPacket_rx_addr_3(oAdr[3]),
    .io_outPacket_rx_data_0(oDat[0]), .io_outPacket_rx_data_1(oDat[1]),
    .io_outPacket_rx_data_2(oDat[2]), .io_outPacket_rx_data_3(oDat[3]),
    .io_flush(flush)
`ifdef VEC_AGG_SCHED_STATS_EN
    ,
    .io_stat_count_0(stat[0]), .io_stat_count_1(stat[1]),
    .io_stat_count_2(stat[2]), .io_stat_count_3(stat[3])
`endif
  );

  // Packet encoding: header = {tag, 6'b0, dest}, addr = {tag, 8'h5A}, data = {8'hC0, tag, ~tag, 8'h3C}.
  function automatic logic [63:0] pk(input logic [1:0] d, input logic [7:0] t);
    return {t, 6'd0, d, t, 8'h5A, 8'hC0, t, ~t, 8'h3C};
  endfunction

  task automatic setIn(input int i, input logic v, input logic [1:0] d, input logic [7:0] t);
    logic [63:0] p;
    p = pk(d, t);
    inValid[i] = v;
    {hdr[i], adr[i], dat[i]} = p;
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    vecs++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  function automatic logic [2:0] rdyVec();
    return {inReady[2], inReady[1], inReady[0]};
  endfunction

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Monitor: every handshake must match the oldest expected packet for that output.
  initial begin
    forever begin
      @(negedge clock);
      if (sbEn && reset === 1'b1) begin
        for (int k = 0; k < 4; k++) begin
          if (outValid[k] && outReady[k]) begin
            if (q[k].size() == 0) begin
              vecs++;
              errs++;
              $display("FAIL unexpected packet on out%0d: got %h, expected none", k, {oHdr[k], oAdr[k], oDat[k]});
            end else begin
              chk($sformatf("out%0d packet", k), {oHdr[k], oAdr[k], oDat[k]}, q[k].pop_front());
            end
          end
        end
      end
    end
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] tg [3];
    int seq [6];
    seq = '{0, 1, 2, 0, 1, 2};
    flush = 1'b0;
    reset = 1'b0;
    for (int k = 0; k < 4; k++) outReady[k] = 1'b1;
    for (int i = 0; i < 3; i++) setIn(i, 1'b1, 2'd0, 8'(i + 8'h40));

    // Reset state
    #3;
    chk("reset in_ready", 64'(rdyVec()), 64'd0);
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("reset out_valid%0d", k), 64'(outValid[k]), 64'd0);
      chk($sformatf("reset out%0d fields", k), {oHdr[k], oAdr[k], oDat[k]}, 64'd0);
    end
    for (int i = 0; i < 3; i++) inValid[i] = 1'b0;
    #19 reset = 1'b1;
    tick();

    // Three inputs contend for output 2: grants rotate 0,1,2,0,1,2
    tg = '{8'h01, 8'h02, 8'h03};
    for (int i = 0; i < 3; i++) setIn(i, 1'b1, 2'd2, tg[i]);
    for (int c = 0; c < 6; c++) begin
      #1;
      chk($sformatf("rr grant c%0d", c), 64'(rdyVec()), 64'(3'b001 << seq[c]));
      q[2].push_back(pk(2'd2, tg[seq[c]]));
      if (c > 0) chk($sformatf("rr out_valid2 c%0d", c), 64'(outValid[2]), 64'd1);
      tick();
      tg[seq[c]] = tg[seq[c]] + 8'd3;
      setIn(seq[c], 1'b1, 2'd2, tg[seq[c]]);
    end
    for (int i = 0; i < 3; i++) inValid[i] = 1'b0;
    #1 chk("rr out_valid2 last", 64'(outValid[2]), 64'd1);
    tick();
    tick();

    // Parallel grants: inputs 0/1/2 -> outputs 3/1/0
    setIn(0, 1'b1, 2'd3, 8'h20);
    setIn(1, 1'b1, 2'd1, 8'h21);
    setIn(2, 1'b1, 2'd0, 8'h22);
    #1 chk("parallel grants", 64'(rdyVec()), 64'(3'b111));
    q[3].push_back(pk(2'd3, 8'h20));
    q[1].push_back(pk(2'd1, 8'h21));
    q[0].push_back(pk(2'd0, 8'h22));
    tick();
    for (int i = 0; i < 3; i++) inValid[i] = 1'b0;
    tick();
    tick();

    // Backpressure on output 1
    outReady[1] = 1'b0;
    setIn(1, 1'b1, 2'd1, 8'h30);
    #1 chk("bp first grant", 64'(rdyVec()), 64'(3'b010));
    q[1].push_back(pk(2'd1, 8'h30));
    tick();
    inValid[1] = 1'b0;
    setIn(0, 1'b1, 2'd1, 8'h31);
    for (int r = 0; r < 3; r++) begin
      #1;
      chk($sformatf("bp blocked r%0d", r), 64'(rdyVec()), 64'd0);
      chk($sformatf("bp held r%0d", r), {oHdr[1], oAdr[1], oDat[1]}, pk(2'd1, 8'h30));
      tick();
    end
    outReady[1] = 1'b1;
    #1 chk("bp release grant", 64'(rdyVec()), 64'(3'b001));
    q[1].push_back(pk(2'd1, 8'h31));
    tick();
    inValid[0] = 1'b0;
    #1 chk("bp new packet", {oHdr[1], oAdr[1], oDat[1]}, pk(2'd1, 8'h31));
    tick();
    tick();

    // Flush with outputs 0 and 3 holding packets
    for (int k = 0; k < 4; k++) outReady[k] = 1'b0;
    setIn(0, 1'b1, 2'd0, 8'h50);
    setIn(2, 1'b1, 2'd3, 8'h52);
    #1 chk("flush setup grants", 64'(rdyVec()), 64'(3'b101));
    tick();
    inValid[0] = 1'b0;
    inValid[2] = 1'b0;
    setIn(1, 1'b1, 2'd2, 8'h51);
    flush = 1'b1;
    #1;
    chk("flush held", 64'({outValid[3], outValid[0]}), 64'(2'b11));
    chk("flush in_ready", 64'(rdyVec()), 64'd0);
    tick();
    flush = 1'b0;
    inValid[1] = 1'b0;
    #1 chk("flush cleared", 64'({outValid[3], outValid[2], outValid[0]}), 64'd0);
    for (int k = 0; k < 4; k++) outReady[k] = 1'b1;
    tick();

    // Asynchronous reset while output 0 holds a packet
    outReady[0] = 1'b0;
    setIn(1, 1'b1, 2'd0, 8'h60);
    #1 chk("areset setup grant", 64'(rdyVec()), 64'(3'b010));
    tick();
    inValid[1] = 1'b0;
    #1 chk("areset held", 64'(outValid[0]), 64'd1);
    #2 reset = 1'b0;
    #1;
    chk("areset out_valid0", 64'(outValid[0]), 64'd0);
    chk("areset out0 fields", {oHdr[0], oAdr[0], oDat[0]}, 64'd0);
    for (int i = 0; i < 3; i++) setIn(i, 1'b1, 2'd0, 8'(8'h70 + i));
    #1 chk("areset in_ready", 64'(rdyVec()), 64'd0);
    @(posedge clock);
    #3 reset = 1'b1;
    #1 chk("areset ptr restart", 64'(rdyVec()), 64'(3'b001));
    q[0].push_back(pk(2'd0, 8'h70));
    outReady[0] = 1'b1;
    tick();
    for (int i = 0; i < 3; i++) inValid[i] = 1'b0;
    #1 chk("areset resumed", 64'(outValid[0]), 64'd1);
    tick();
    tick();

`ifdef VEC_AGG_SCHED_STATS_EN
    // Saturating handshake counter on output 2
    chk("stat2 after reset", 64'(stat[2]), 64'd0);
    sbEn = 1'b0;
    setIn(0, 1'b1, 2'd2, 8'h80);
    repeat (11) tick();
    chk("stat2 count", 64'(stat[2]), 64'd10);
    repeat (70000) tick();
    chk("stat2 saturated", 64'(stat[2]), 64'hFFFF);
    inValid[0] = 1'b0;
    tick();
    tick();
    sbEn = 1'b1;
`endif

    for (int k = 0; k < 4; k++) chk($sformatf("out%0d leftover", k), 64'(q[k].size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
